multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning the number of memory-wait cycles after which the block traps (valid range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the wait counter; TIMEOUT_CYC SHALL be at most 2^CNT_W-1.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports listed below.
REQ-004 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port op_i, input, 7 bits: opcode of the latched instruction.
REQ-007 SHALL have port funct7_i, input, 7 bits: funct7 of the latched instruction.
REQ-008 SHALL have port mem_ready_i, input, 1 bit: memory completes the current request.
REQ-009 SHALL have port alu_done_i, input, 1 bit: multi-cycle ALU result valid.
REQ-010 SHALL have port mem_req_o, output, 1 bit: memory request.
REQ-011 SHALL have port mem_we_o, output, 1 bit: memory write, valid with mem_req_o.
REQ-012 SHALL have port ir_write_o, output, 1 bit: latch the fetched instruction.
REQ-013 SHALL have port ALUOp_o, output, 2 bits: ALU op class (00 add, 01 sub, 10 R-type, 11 I-type).
REQ-014 SHALL have port ALUSrc_o, output, 1 bit: select immediate operand.
REQ-015 SHALL have port RegWrite_o, output, 1 bit: register-file write strobe.
REQ-016 SHALL have port pc_write_o, output, 1 bit: PC update strobe.
REQ-017 SHALL have port trap_o, output, 1 bit: sticky trap flag.
REQ-018 SHALL have port cause_o, output, 2 bits: trap cause (00 none, 01 illegal opcode, 10 memory timeout).
REQ-019 SHALL have port state_o, output, 3 bits: current FSM state encoding.

Function
REQ-020 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, EXEC_WAIT=3, MEM=4, WB=5 and TRAP=6, all registered.
REQ-021 In FETCH, SHALL assert mem_req_o=1 with mem_we_o=0; on mem_ready_i it SHALL pulse ir_write_o and go to DECODE.
REQ-022 In DECODE, SHALL decode the opcodes R=0110011, I=0010011, LOAD=0000011, STORE=0100011 and BRANCH=1100011; any other opcode SHALL go to TRAP with cause 01.
REQ-023 EXEC SHALL last one cycle and drive ALUOp_o/ALUSrc_o as follows:
- R-type: 10/0
- I-type: 11/1
- LOAD/STORE: 00/1
- BRANCH: 01/0
REQ-024 From EXEC, SHALL go to WB for R/I, to MEM for LOAD/STORE, and pulse pc_write_o then go to FETCH for BRANCH.
REQ-025 ALUOp_o/ALUSrc_o SHALL hold their last EXEC values in other states and SHALL never be X.
REQ-026 In MEM, SHALL assert mem_req_o, with mem_we_o=1 for STORE; on mem_ready_i, LOAD SHALL go to WB, and STORE SHALL pulse pc_write_o and go to FETCH.
REQ-027 In WB, SHALL pulse RegWrite_o and pc_write_o for exactly one cycle, then go to FETCH.
REQ-028 Minimum cycles per instruction (mem_ready_i high on first request cycle) SHALL be: R/I 4, LOAD 5, STORE 4, BRANCH 3.
REQ-029 The wait counter SHALL clear on entry to FETCH/MEM and on mem_ready_i, and SHALL increment on each cycle with mem_req_o=1 and mem_ready_i=0.
REQ-030 When the counter reaches TIMEOUT_CYC, SHALL go to TRAP with cause 10.
REQ-031 If mem_ready_i arrives in the same cycle the counter reaches TIMEOUT_CYC, completion SHALL win.
REQ-032 TRAP SHALL be absorbing: trap_o=1, cause_o held, all strobes 0, until reset.
REQ-033 RegWrite_o, pc_write_o and ir_write_o SHALL never be asserted in the same cycle as trap_o.

Reset
REQ-034 On rst_i=1 at a clock edge, SHALL set state FETCH, counter 0, trap_o 0, cause_o 00, ALUOp_o 00 and ALUSrc_o 0.
REQ-035 Reset SHALL override any in-flight access; mem_req_o SHALL be 0 in the cycle rst_i is high, and the first FETCH request SHALL follow the cycle after rst_i falls.

Configuration
REQ-036 With macro MULDIV_EN defined, an R-type instruction with funct7=0000001 SHALL go EXEC -> EXEC_WAIT, holding ALUOp_o=10 until alu_done_i, then go to WB.
REQ-037 EXEC_WAIT SHALL have no timeout.
REQ-038 Without MULDIV_EN, EXEC_WAIT SHALL be unreachable, alu_done_i SHALL be ignored, and funct7 SHALL not affect sequencing.

Structure
REQ-039 Opcode constants, ALUOp encodings, cause encodings and the state enum SHALL live in the shared cpu_pkg package.
REQ-040 Opcode-to-class decode SHALL be a combinational sub-module mc_ctrl_decode (inputs op_i/funct7_i; outputs class, legal and muldiv flags).

Verification
REQ-041 The bench SHALL check an R-type op 0110011 with mem_ready_i always 1: states 0,1,2,5; RegWrite_o=1 and pc_write_o=1 at cycle 4; ALUOp_o=10, ALUSrc_o=0.
REQ-042 The bench SHALL check a LOAD with mem_ready_i low 3 cycles in MEM: mem_we_o=0, 8 total cycles, RegWrite_o pulses once.
REQ-043 The bench SHALL check op_i=1111111: in cycle 3, trap_o=1 and cause_o=01; no strobes thereafter over 20 cycles.
REQ-044 The bench SHALL check mem_ready_i held low in FETCH with TIMEOUT_CYC=16: trap after 16 wait cycles with cause_o=10; with mem_ready_i on the 16th cycle, there is no trap.
REQ-045 The bench SHALL check rst_i asserted mid-MEM of a STORE: the next cycle shows state_o=0 and mem_req_o=0, and no pc_write_o pulse occurs.
REQ-046 With MULDIV_EN defined, the bench SHALL check funct7=0000001 and alu_done_i after 5 cycles: EXEC_WAIT held 5 cycles, then WB; without the macro, the same stimulus SHALL take 4 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control slice: opcodes, ALU op classes,
// trap causes, FSM states and instruction classes.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXEC      = 3'd2,
        ST_EXEC_WAIT = 3'd3,
        ST_MEM       = 3'd4,
        ST_WB        = 3'd5,
        ST_TRAP      = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } op_class_e;

    function automatic alu_op_e class_alu_op(input op_class_e cls);
        case (cls)
            CLS_R:      return ALU_RTYPE;
            CLS_I:      return ALU_ITYPE;
            CLS_BRANCH: return ALU_SUB;
            default:    return ALU_ADD;
        endcase
    endfunction

    function automatic logic class_alu_src(input op_class_e cls);
        return (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode-to-class decode. Optional macro MULDIV_EN enables
// flagging R-type funct7=0000001 as a multi-cycle ALU operation.
module mc_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [6:0] funct7_i,
    output op_class_e  op_class_o,
    output logic       legal_o,
    output logic       muldiv_o
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        op_class_o = CLS_R;
        legal_o    = 1'b1;
        case (op_i)
            OP_R:      op_class_o = CLS_R;
            OP_I:      op_class_o = CLS_I;
            OP_LOAD:   op_class_o = CLS_LOAD;
            OP_STORE:  op_class_o = CLS_STORE;
            OP_BRANCH: op_class_o = CLS_BRANCH;
            default:   legal_o    = 1'b0;
        endcase
    end

`ifdef MULDIV_EN
    assign muldiv_o = legal_o && (op_class_o == CLS_R) && (funct7_i == F7_MULDIV);
`else
    logic unused_funct7;
    assign unused_funct7 = ^funct7_i;
    assign muldiv_o      = 1'b0;
`endif

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky trap.
// Macro MULDIV_EN (in mc_ctrl_decode) enables the EXEC_WAIT multi-cycle ALU path.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [6:0] funct7_i,
    input  logic       mem_ready_i,
    input  logic       alu_done_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       ir_write_o,
    output logic [1:0] ALUOp_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       pc_write_o,
    output logic       trap_o,
    output logic [1:0] cause_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e     state_q, state_d;
    op_class_e  cls_q, dec_cls;
    logic       dec_legal, dec_muldiv, muldiv_q;
    alu_op_e    alu_op_q;
    logic       alu_src_q;
    cause_e     cause_q;
    logic [CNT_W-1:0] cnt_q;

    logic mem_req, mem_we, ir_write, reg_write, pc_write, timeout;

    mc_ctrl_decode u_decode (
        .op_i       (op_i),
        .funct7_i   (funct7_i),
        .op_class_o (dec_cls),
        .legal_o    (dec_legal),
        .muldiv_o   (dec_muldiv)
    );

    assign mem_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
    // Reaching TIMEOUT_CYC happens on the edge after the last allowed wait cycle.
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_I:        state_d = muldiv_q ? ST_EXEC_WAIT : ST_WB;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default: begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_WAIT: if (alu_done_i) state_d = ST_WB;
            ST_MEM: begin
                mem_we = (cls_q == CLS_STORE);
                if (mem_ready_i) begin
                    pc_write = (cls_q == CLS_STORE);
                    state_d  = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            cause_q   <= CAUSE_NONE;
            alu_op_q  <= ALU_ADD;
            alu_src_q <= 1'b0;
            cls_q     <= CLS_R;
            muldiv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE && dec_legal) begin
                cls_q     <= dec_cls;
                muldiv_q  <= dec_muldiv;
                alu_op_q  <= class_alu_op(dec_cls);
                alu_src_q <= class_alu_src(dec_cls);
            end
            if (state_q != ST_TRAP && state_d == ST_TRAP)
                cause_q <= (state_q == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
            if (mem_ready_i ||
                (state_d != state_q && (state_d == ST_FETCH || state_d == ST_MEM)))
                cnt_q <= '0;
            else if (mem_req)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Reset suppresses every request and strobe in the cycle it is asserted.
    assign mem_req_o  = mem_req && !rst_i;
    assign mem_we_o   = mem_we && !rst_i;
    assign ir_write_o = ir_write && !rst_i;
    assign RegWrite_o = reg_write && !rst_i;
    assign pc_write_o = pc_write && !rst_i;
    assign ALUOp_o    = alu_op_q;
    assign ALUSrc_o   = alu_src_q;
    assign trap_o     = (state_q == ST_TRAP);
    assign cause_o    = cause_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (TIMEOUT_CYC=16).
module tb_multicycle_control;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_i = 7'd0;
    logic [6:0] funct7_i = 7'd0;
    logic       mem_ready_i = 1'b0;
    logic       alu_done_i = 1'b0;
    logic       mem_req_o, mem_we_o, ir_write_o, ALUSrc_o, RegWrite_o, pc_write_o, trap_o;
    logic [1:0] ALUOp_o, cause_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_control #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .op_i        (op_i),
        .funct7_i    (funct7_i),
        .mem_ready_i (mem_ready_i),
        .alu_done_i  (alu_done_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .ir_write_o  (ir_write_o),
        .ALUOp_o     (ALUOp_o),
        .ALUSrc_o    (ALUSrc_o),
        .RegWrite_o  (RegWrite_o),
        .pc_write_o  (pc_write_o),
        .trap_o      (trap_o),
        .cause_o     (cause_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        mem_ready_i = 1'b0;
        alu_done_i  = 1'b0;
        tick();
        check("rst_req_low", int'(mem_req_o), 0);
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    // Runs one instruction starting in FETCH; stalls MEM for mem_stall cycles,
    // raises alu_done_i in cycle 8. Returns -1 cycles if FETCH never recurs.
    task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input int mem_stall,
                             output int cycles, output int rw, output int pc,
                             output int we, output int ew);
        int  stall = mem_stall;
        bit  done  = 1'b0;
        cycles = -1; rw = 0; pc = 0; we = 0; ew = 0;
        op_i = op; funct7_i = f7;
        for (int c = 1; c <= 60 && !done; c++) begin
            mem_ready_i = !(state_o == 3'd4 && stall > 0);
            if (state_o == 3'd4 && stall > 0) stall--;
            alu_done_i = (c == 8);
            #1;
            rw += int'(RegWrite_o);
            pc += int'(pc_write_o);
            we += int'(mem_req_o && mem_we_o);
            ew += int'(state_o == 3'd3);
            tick();
            if (state_o == 3'd0) begin
                cycles = c;
                done   = 1'b1;
            end
        end
        alu_done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rw, pc, we, ew, strobes;

        // Reset state
        do_reset();
        check("rst_state", int'(state_o), 0);
        check("rst_trap", int'(trap_o), 0);
        check("rst_cause", int'(cause_o), 0);
        check("rst_aluop", int'(ALUOp_o), 0);
        check("rst_alusrc", int'(ALUSrc_o), 0);
        check("rst_first_req", int'(mem_req_o), 1);

        // R-type, mem_ready always 1: states 0,1,2,5
        op_i = 7'b0110011; funct7_i = 7'd0; mem_ready_i = 1'b1;
        #1;
        check("r_c1_state", int'(state_o), 0);
        check("r_c1_we", int'(mem_we_o), 0);
        check("r_c1_irw", int'(ir_write_o), 1);
        tick();
        check("r_c2_state", int'(state_o), 1);
        tick();
        check("r_c3_state", int'(state_o), 2);
        check("r_c3_aluop", int'(ALUOp_o), 2);
        check("r_c3_alusrc", int'(ALUSrc_o), 0);
        tick();
        check("r_c4_state", int'(state_o), 5);
        check("r_c4_regwrite", int'(RegWrite_o), 1);
        check("r_c4_pcwrite", int'(pc_write_o), 1);
        tick();
        check("r_c5_state", int'(state_o), 0);

        // LOAD with 3 stall cycles in MEM
        run_instr(7'b0000011, 7'd0, 3, cyc, rw, pc, we, ew);
        check("ld_cycles", cyc, 8);
        check("ld_regwrite", rw, 1);
        check("ld_pcwrite", pc, 1);
        check("ld_we", we, 0);
        check("ld_aluop_hold", int'(ALUOp_o), 0);
        check("ld_alusrc_hold", int'(ALUSrc_o), 1);

        // STORE, no stall
        run_instr(7'b0100011, 7'd0, 0, cyc, rw, pc, we, ew);
        check("st_cycles", cyc, 4);
        check("st_regwrite", rw, 0);
        check("st_pcwrite", pc, 1);
        check("st_we", we, 1);

        // BRANCH
        run_instr(7'b1100011, 7'd0, 0, cyc, rw, pc, we, ew);
        check("br_cycles", cyc, 3);
        check("br_regwrite", rw, 0);
        check("br_pcwrite", pc, 1);
        check("br_aluop_hold", int'(ALUOp_o), 1);
        check("br_alusrc_hold", int'(ALUSrc_o), 0);

        // I-type
        run_instr(7'b0010011, 7'd0, 0, cyc, rw, pc, we, ew);
        check("i_cycles", cyc, 4);
        check("i_regwrite", rw, 1);
        check("i_aluop_hold", int'(ALUOp_o), 3);
        check("i_alusrc_hold", int'(ALUSrc_o), 1);

        // R-type funct7=0000001, alu_done_i in cycle 8 (5th EXEC_WAIT cycle)
        run_instr(7'b0110011, 7'b0000001, 0, cyc, rw, pc, we, ew);
`ifdef MULDIV_EN
        check("md_cycles", cyc, 9);
        check("md_ew_cycles", ew, 5);
`else
        check("md_cycles", cyc, 4);
        check("md_ew_cycles", ew, 0);
`endif
        check("md_regwrite", rw, 1);
        check("md_aluop_hold", int'(ALUOp_o), 2);

        // Illegal opcode traps in cycle 3 and absorbs
        do_reset();
        op_i = 7'b1111111; funct7_i = 7'd0; mem_ready_i = 1'b1;
        tick();
        tick();
        check("ill_c3_trap", int'(trap_o), 1);
        check("ill_c3_cause", int'(cause_o), 1);
        check("ill_c3_state", int'(state_o), 6);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            strobes += int'(RegWrite_o) + int'(pc_write_o) + int'(ir_write_o) + int'(mem_req_o);
            tick();
        end
        check("ill_no_strobes", strobes, 0);
        check("ill_trap_sticky", int'(trap_o), 1);
        check("ill_cause_held", int'(cause_o), 1);

        // FETCH timeout after 16 wait cycles
        do_reset();
        op_i = 7'b0110011; mem_ready_i = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (c == 16) begin
                check("to_c16_state", int'(state_o), 0);
                check("to_c16_trap", int'(trap_o), 0);
            end
            tick();
        end
        check("to_trap", int'(trap_o), 1);
        check("to_cause", int'(cause_o), 2);
        check("to_req_off", int'(mem_req_o), 0);

        // Ready on the 16th wait cycle wins over timeout
        do_reset();
        mem_ready_i = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            mem_ready_i = (c == 16);
            #1;
            if (c == 16) check("race_irw", int'(ir_write_o), 1);
            tick();
        end
        check("race_state", int'(state_o), 1);
        check("race_trap", int'(trap_o), 0);
        check("race_cause", int'(cause_o), 0);

        // Reset in the middle of a STORE's MEM phase
        do_reset();
        op_i = 7'b0100011; mem_ready_i = 1'b1;
        tick();
        tick();
        tick();
        mem_ready_i = 1'b0;
        #1;
        check("rm_mem_state", int'(state_o), 4);
        check("rm_mem_we", int'(mem_we_o), 1);
        tick();
        rst_i = 1'b1; mem_ready_i = 1'b1;
        #1;
        check("rm_rst_req", int'(mem_req_o), 0);
        check("rm_rst_pcw", int'(pc_write_o), 0);
        tick();
        check("rm_next_state", int'(state_o), 0);
        check("rm_next_req", int'(mem_req_o), 0);
        check("rm_next_pcw", int'(pc_write_o), 0);
        tick();
        rst_i = 1'b0;
        #1;
        check("rm_after_state", int'(state_o), 0);
        check("rm_after_req", int'(mem_req_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
